// File: rtl/pixel_serializer.sv
// Channel-serial RGB transmitter: accepts one packed {R,G,B} pixel per handshake
// and emits its three channels as a byte stream, in RGB or BGR order.
module pixel_serializer #(
   parameter int COLOR_W   = 8,
   parameter int BGR_ORDER = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic [3*COLOR_W-1:0] pix_data,
   input  logic                 pix_last,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic [COLOR_W-1:0]   byte_data,
   output logic [1:0]           byte_chan,
   output logic                 byte_last,
   output logic [31:0]          pix_count
);

   // Both ports use valid/ready: a transfer happens on a rising edge where
   // valid && ready are both high; valid and payload hold while ready is low.
   typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

   state_t               state;
   logic [3*COLOR_W-1:0] hold_data;
   logic                 hold_last;
   logic [31:0]          count;
   logic [1:0]           pos;
   logic [1:0]           chan;
   logic                 active;
   logic                 pix_hs;
   logic                 byte_hs;

   assign pix_ready = rst_n && ((state == IDLE) || ((state == S2) && byte_ready));
   assign pix_hs    = pix_valid && pix_ready;
   assign byte_hs   = byte_valid && byte_ready;
   assign pix_count = count;

   // Outputs decode only from state and the holding register, never pix_data.
   always_comb begin
      pos    = 2'd0;
      active = 1'b0;
      case (state)
         S0:      begin pos = 2'd0; active = 1'b1; end
         S1:      begin pos = 2'd1; active = 1'b1; end
         S2:      begin pos = 2'd2; active = 1'b1; end
         default: begin pos = 2'd0; active = 1'b0; end
      endcase
      chan       = (BGR_ORDER != 0) ? (2'd2 - pos) : pos;
      byte_valid = active;
      byte_chan  = active ? chan : 2'd0;
      case (chan)
         2'd0:    byte_data = hold_data[3*COLOR_W-1:2*COLOR_W];
         2'd1:    byte_data = hold_data[2*COLOR_W-1:COLOR_W];
         default: byte_data = hold_data[COLOR_W-1:0];
      endcase
      if (!active) byte_data = '0;
      byte_last = (state == S2) && hold_last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_last <= 1'b0;
         count     <= 32'd0;
      end else begin
         case (state)
            IDLE: if (pix_hs) state <= S0;
            S0:   if (byte_hs) state <= S1;
            S1:   if (byte_hs) state <= S2;
            S2: begin
               if (byte_hs) begin
                  count <= count + 32'd1;
                  state <= pix_hs ? S0 : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (pix_hs) begin
            hold_data <= pix_data;
            hold_last <= pix_last;
         end
      end
   end

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: an RGB-order and a BGR-order instance share stimulus
// and are checked every cycle against a queue-based model of the byte stream.
module tb_pixel_serializer;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pix_valid;
   logic [3*W-1:0] pix_data;
   logic          pix_last;
   logic          byte_ready;

   logic          pix_ready0, byte_valid0, byte_last0;
   logic [W-1:0]  byte_data0;
   logic [1:0]    byte_chan0;
   logic [31:0]   pix_count0;
   logic          pix_ready1, byte_valid1, byte_last1;
   logic [W-1:0]  byte_data1;
   logic [1:0]    byte_chan1;
   logic [31:0]   pix_count1;

   int checks = 0;
   int errors = 0;

   // model state: expected bytes {pos[1:0], last, chan[1:0], data[7:0]}
   logic [12:0] q0[$];
   logic [12:0] q1[$];
   logic [31:0] m_count = 32'd0;
   bit          preload_req = 1'b0;
   // bytes actually delivered by each DUT: {last, chan, data}
   logic [10:0] cap0[$];
   logic [10:0] cap1[$];

   pixel_serializer #(.COLOR_W(W), .BGR_ORDER(0)) u0 (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready0),
      .pix_data(pix_data), .pix_last(pix_last), .byte_valid(byte_valid0),
      .byte_ready(byte_ready), .byte_data(byte_data0), .byte_chan(byte_chan0),
      .byte_last(byte_last0), .pix_count(pix_count0));

   pixel_serializer #(.COLOR_W(W), .BGR_ORDER(1)) u1 (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready1),
      .pix_data(pix_data), .pix_last(pix_last), .byte_valid(byte_valid1),
      .byte_ready(byte_ready), .byte_data(byte_data1), .byte_chan(byte_chan1),
      .byte_last(byte_last1), .pix_count(pix_count1));

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] chan_val(input logic [23:0] p, input int c);
      return p[(2-c)*8 +: 8];
   endfunction

   function automatic logic [12:0] mk_entry(input logic [23:0] p, input logic l,
                                            input int k, input int bgr);
      int c;
      c = bgr ? (2 - k) : k;
      return {k[1:0], (k == 2) && l, c[1:0], chan_val(p, c)};
   endfunction

   // scoreboard: inputs change just after posedge, so at negedge everything is
   // settled and the handshakes of the coming edge are known
   always @(negedge clk) begin
      logic        exp_ready;
      logic [12:0] e0, e1;
      if (preload_req) begin
         m_count = 32'hFFFF_FFFF;
         preload_req = 1'b0;
      end
      exp_ready = rst_n && ((q0.size() == 0) || ((q0.size() == 1) && byte_ready));
      chk("pix_ready0", pix_ready0, exp_ready);
      chk("pix_ready1", pix_ready1, exp_ready);
      chk("byte_valid0", byte_valid0, q0.size() != 0);
      chk("byte_valid1", byte_valid1, q1.size() != 0);
      chk("pix_count0", pix_count0, m_count);
      chk("pix_count1", pix_count1, m_count);
      if (q0.size() != 0) chk("byte0", {byte_last0, byte_chan0, byte_data0}, q0[0][10:0]);
      if (q1.size() != 0) chk("byte1", {byte_last1, byte_chan1, byte_data1}, q1[0][10:0]);
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         m_count = 32'd0;
      end else begin
         if (q0.size() != 0 && byte_ready) begin
            e0 = q0.pop_front();
            if (q1.size() != 0) e1 = q1.pop_front();
            cap0.push_back({byte_last0, byte_chan0, byte_data0});
            cap1.push_back({byte_last1, byte_chan1, byte_data1});
            if (e0[12:11] == 2'd2) m_count = m_count + 32'd1;
         end
         if (pix_valid && exp_ready) begin
            for (int k = 0; k < 3; k++) begin
               q0.push_back(mk_entry(pix_data, pix_last, k, 0));
               q1.push_back(mk_entry(pix_data, pix_last, k, 1));
            end
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixel(input logic [23:0] d, input logic l);
      bit hs = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = l;
      for (int i = 0; i < 50 && !hs; i++) begin
         @(negedge clk);
         hs = pix_ready0;
         step();
      end
      if (!hs) chk("send_timeout", 32'd0, 32'd1);
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (byte_valid0 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_cap(input string name, input int inst, input logic [10:0] exp[]);
      int sz;
      sz = (inst == 0) ? cap0.size() : cap1.size();
      chk({name, "_len"}, sz, exp.size());
      for (int i = 0; i < exp.size() && i < sz; i++)
         chk(name, (inst == 0) ? cap0[i] : cap1[i], exp[i]);
   endtask

   initial begin
      rst_n = 1'b0; pix_valid = 1'b1; pix_data = 24'h123456; pix_last = 1'b1; byte_ready = 1'b1;
      // reset held for 3 cycles with a pixel offered
      repeat (3) step();
      rst_n = 1'b1; pix_valid = 1'b0;
      @(negedge clk);
      chk("rst_pix_ready", pix_ready0, 1);
      chk("rst_byte_valid", byte_valid0, 0);
      chk("rst_byte_outs", {byte_last1, byte_chan1, byte_data1}, 0);
      chk("rst_count", pix_count1, 0);
      step();

      // single pixel
      cap0.delete(); cap1.delete();
      send_pixel({8'd25, 8'd55, 8'd98}, 1'b0);
      wait_idle();
      chk_cap("rgb_single", 0, '{{1'b0, 2'd0, 8'd25}, {1'b0, 2'd1, 8'd55}, {1'b0, 2'd2, 8'd98}});
      chk_cap("bgr_single", 1, '{{1'b0, 2'd2, 8'd98}, {1'b0, 2'd1, 8'd55}, {1'b0, 2'd0, 8'd25}});
      chk("single_count", pix_count0, 1);

      // back-to-back with last
      cap0.delete(); cap1.delete();
      send_pixel({8'd45, 8'd75, 8'd95}, 1'b0);
      send_pixel({8'd10, 8'd20, 8'd30}, 1'b1);
      wait_idle();
      chk_cap("bgr_b2b", 1, '{{1'b0, 2'd2, 8'd95}, {1'b0, 2'd1, 8'd75}, {1'b0, 2'd0, 8'd45},
                             {1'b0, 2'd2, 8'd30}, {1'b0, 2'd1, 8'd20}, {1'b1, 2'd0, 8'd10}});
      chk("b2b_count", pix_count1, 3);

      // backpressure for 4 cycles in S1
      cap0.delete();
      send_pixel({8'd1, 8'd2, 8'd3}, 1'b1);
      step();
      byte_ready = 1'b0;
      repeat (4) step();
      byte_ready = 1'b1;
      wait_idle();
      chk_cap("rgb_bp", 0, '{{1'b0, 2'd0, 8'd1}, {1'b0, 2'd1, 8'd2}, {1'b1, 2'd2, 8'd3}});

      // reset in S1, then a fresh pixel
      send_pixel({8'd7, 8'd8, 8'd9}, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_valid", byte_valid0, 0);
      chk("midrst_count", pix_count0, 0);
      step();
      cap0.delete();
      send_pixel({8'd11, 8'd22, 8'd33}, 1'b0);
      wait_idle();
      chk_cap("rgb_after_rst", 0, '{{1'b0, 2'd0, 8'd11}, {1'b0, 2'd1, 8'd22}, {1'b0, 2'd2, 8'd33}});

      // randomized traffic with occasional resets
      for (int i = 0; i < 2000; i++) begin
         rst_n      = ($urandom_range(0, 99) != 0);
         pix_valid  = ($urandom_range(0, 9) < 7);
         pix_data   = $urandom();
         pix_last   = $urandom_range(0, 1);
         byte_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rst_n = 1'b1; pix_valid = 1'b0; byte_ready = 1'b1;
      step();
      wait_idle();

      // counter wrap
      force u0.count = 32'hFFFF_FFFF;
      force u1.count = 32'hFFFF_FFFF;
      preload_req = 1'b1;
      #1;
      release u0.count;
      release u1.count;
      step();
      send_pixel({8'd200, 8'd100, 8'd50}, 1'b0);
      wait_idle();
      @(negedge clk);
      chk("wrap_count", pix_count0, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_serializer.md
# pixel_serializer

Channel-serial transmitter for RGB pixels. It accepts one packed pixel per handshake and emits its three colour channels as a byte stream, one channel per handshake. It sits downstream of the blocks that build pixels as R/G/B structs and drives narrow links such as display or sensor-emulation buses. It is the unpacking counterpart of pixel construction: struct in, ordered channel bytes out.

## Interface
Parameters:
- COLOR_W, 8, width of one colour channel.
- BGR_ORDER, 0, transmit order: 0 sends R,G,B; 1 sends B,G,R.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- pix_valid  input  1  pixel offered.
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
- pix_data  input  3*COLOR_W  packed pixel {R,G,B}, with R in the MSBs and B in the LSBs.
- pix_last  input  1  end-of-line marker for this pixel.
- byte_valid  output  1  channel byte available.
- byte_ready  input  1  sink accepts the byte when byte_valid && byte_ready.
- byte_data  output  COLOR_W  current channel value.
- byte_chan  output  2  channel ID of byte_data: 0=R, 1=G, 2=B. Value 3 never occurs.
- byte_last  output  1  high on the final channel byte of a pixel whose pix_last was 1.
- pix_count  output  32  count of fully transmitted pixels; unsigned, wraps 2^32-1 -> 0.

## Operation
- **Pixel register:** the block holds pix_data and pix_last in a holding register, loaded on each pixel handshake.
- **FSM states:** IDLE, S0, S1, S2. S0/S1/S2 are the first, second and third transmitted channel.
  - BGR_ORDER=0: S0=R, S1=G, S2=B.
  - BGR_ORDER=1: S0=B, S1=G, S2=R.
- **Transitions:**
  - IDLE -> S0 on a pixel handshake.
  - S0 -> S1 on a byte handshake.
  - S1 -> S2 on a byte handshake.
  - S2, byte handshake, and a simultaneous pixel handshake -> S0, with the new pixel loaded.
  - S2, byte handshake, no pixel handshake -> IDLE.
  - In any state, no byte handshake -> hold.
- **pix_ready** = (state==IDLE) || (state==S2 && byte_ready). It is combinational from state and byte_ready, and forced 0 while rst_n is low.
- **byte_valid** = state is S0, S1 or S2.
- **byte outputs:** byte_data and byte_chan select from the holding register by state and BGR_ORDER.
- **byte_last** = (state==S2) && held pix_last. It is 0 in S0 and S1.
- **pix_count** increments by 1 on each S2 byte handshake.
- **Ignored inputs:** pix_data and pix_last are ignored unless a pixel handshake occurs.

## Timing
- **Reset (rst_n low at a clock edge):**
  - state=IDLE
  - holding register=0
  - pix_count=0
  - byte_valid=0, byte_data=0, byte_chan=0, byte_last=0
  - pix_ready=0 while rst_n is low, 1 in the first cycle after release.
- **Mid-operation reset:** reset in any state aborts the pixel in flight. No partial bytes are emitted after release and pix_count stays 0.
- **Latency:** a pixel handshake at edge N presents the S0 byte valid in the cycle after edge N.
- **Throughput:** with byte_ready held 1 and pix_valid held 1, one byte per cycle with no bubbles. Pixels are accepted every 3 cycles.
- **Backpressure:** while byte_valid && !byte_ready, byte_data, byte_chan and byte_last hold stable and pix_ready=0.
- **Source bubble:** if pix_valid is 0 at the S2 handshake, byte_valid drops to 0 for at least one cycle (IDLE).
- **Outputs:** byte_data, byte_chan and byte_last are registered-path values: decoded from state and the holding register only, with no combinational dependence on pix_data.
- **pix_count update:** pix_count updates the cycle after the S2 handshake. A wrap from 32'hFFFF_FFFF gives 0 with no other effect.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with pix_valid=1 -> pix_ready=0, byte_valid=0, pix_count=0; after release pix_ready=1.
- **Single pixel, BGR_ORDER=0:** pixel {8'd25,8'd55,8'd98}, pix_last=0, byte_ready=1 -> bytes 25/55/98 with chan 0/1/2 in 3 consecutive cycles; byte_last always 0; pix_count=1.
- **Back-to-back with last, BGR_ORDER=1:** pixels {45,75,95} then {10,20,30} with pix_last=1 on the second, byte_ready=1 -> bytes 95,75,45,30,20,10 with no bubble; chan 2,1,0,2,1,0; byte_last=1 only on the final byte (10); pix_count=2.
- **Backpressure:** byte_ready=0 for 4 cycles while in S1 -> byte_data=G and byte_chan=1 held stable; pix_ready=0; resume with no byte lost or duplicated.
- **Reset mid-pixel:** assert rst_n=0 in S1 -> next cycle byte_valid=0 and pix_count=0; a subsequent pixel transmits from S0 correctly.
- **Counter wrap:** preload pix_count to 32'hFFFF_FFFF via force, send one pixel -> pix_count=0.
